// File: rtl/atm_controller.sv
// Card-ATM controller: PIN entry with 3-try lockout, deposit/withdraw on a stored balance, PIN change.
// Push buttons are edge-detected internally; LEDs and 7-segment digits decode the registered state.
module atm_controller #(
  parameter int unsigned LOCK_LONG_CYC  = 500_000_000,
  parameter int unsigned LOCK_SHORT_CYC = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTN3,
  input  logic       BTN2,
  input  logic       BTN1,
  input  logic [3:0] SW,
  output logic [7:0] LED,
  output logic [6:0] digit4,
  output logic [6:0] digit3,
  output logic [6:0] digit2,
  output logic [6:0] digit1
);

  localparam int unsigned TW = 32;
  localparam logic [TW-1:0] LONG_LAST  = TW'(LOCK_LONG_CYC - 1);
  localparam logic [TW-1:0] SHORT_LAST = TW'(LOCK_SHORT_CYC - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_L     = 7'h47;

  // Encoding doubles as the digit4 state code and the LED bit index.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PIN        = 3'd1,
    MENU       = 3'd2,
    MONEY      = 3'd3,
    PW_OLD     = 3'd4,
    PW_NEW     = 3'd5,
    LOCK_PIN   = 3'd6,
    LOCK_FUNDS = 3'd7
  } state_t;

  state_t        state;
  logic [3:0]    pin;
  logic [7:0]    balance;
  logic [1:0]    tries;
  logic [TW-1:0] timer;
  logic [2:0]    btn_s;
  logic [2:0]    btn_p;
  logic [2:0]    press;
  logic [8:0]    dep_sum;
  logic          pin_ok;

  // press bits are {BTN3, BTN2, BTN1}; one pulse per rising edge of the sampled button.
  assign press   = btn_s & ~btn_p;
  assign dep_sum = {1'b0, balance} + {5'b0_0000, SW};
  assign pin_ok  = (SW == pin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pin     <= 4'd0;
      balance <= 8'd0;
      tries   <= 2'd0;
      timer   <= '0;
      btn_s   <= 3'd0;
      btn_p   <= 3'd0;
    end else begin
      btn_s <= {BTN3, BTN2, BTN1};
      btn_p <= btn_s;
      case (state)
        IDLE: begin
          if (press[2]) begin
            state <= PIN;
            tries <= 2'd0;
          end
        end
        PIN, PW_OLD: begin
          if (press[0]) begin
            state <= (state == PIN) ? IDLE : MENU;
          end else if (press[2]) begin
            if (pin_ok) begin
              state <= (state == PIN) ? MENU : PW_NEW;
              tries <= 2'd0;
            end else if (tries == 2'd2) begin
              state <= LOCK_PIN;
              tries <= 2'd0;
              timer <= '0;
            end else begin
              tries <= tries + 2'd1;
            end
          end
        end
        MENU: begin
          if (press[0]) begin
            state <= IDLE;
          end else if (press[2]) begin
            state <= MONEY;
          end else if (press[1]) begin
            state <= PW_OLD;
            tries <= 2'd0;
          end
        end
        MONEY: begin
          if (press[0]) begin
            state <= MENU;
          end else if (press[2]) begin
            balance <= dep_sum[8] ? 8'hFF : dep_sum[7:0];
          end else if (press[1]) begin
            if ({4'b0000, SW} <= balance) begin
              balance <= balance - {4'b0000, SW};
            end else begin
              state <= LOCK_FUNDS;
              timer <= '0;
            end
          end
        end
        PW_NEW: begin
          if (press[0]) begin
            state <= MENU;
          end else if (press[2]) begin
            pin   <= SW;
            state <= MENU;
          end
        end
        LOCK_PIN: begin
          if (timer == LONG_LAST) begin
            state <= IDLE;
            tries <= 2'd0;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        LOCK_FUNDS: begin
          if (timer == SHORT_LAST) begin
            state <= MONEY;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    LED    = 8'd1 << state;
    digit4 = seg7({1'b0, state});
    digit3 = SEG_BLANK;
    digit2 = SEG_BLANK;
    digit1 = SEG_BLANK;
    case (state)
      MENU, MONEY: begin
        digit3 = seg7(4'(balance / 8'd100));
        digit2 = seg7(4'((balance / 8'd10) % 8'd10));
        digit1 = seg7(4'(balance % 8'd10));
      end
      PIN, PW_OLD: digit1 = seg7({2'b00, 2'd3 - tries});
      LOCK_PIN, LOCK_FUNDS: digit4 = SEG_L;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_atm_controller.sv
// Directed table-driven bench for atm_controller with short lock lengths.
module tb_atm_controller;

  localparam int unsigned LONG  = 80;
  localparam int unsigned SHORT = 40;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, SL = 7'h47, SB = 7'h7F;
  localparam logic [2:0] K1 = 3'b001, K2 = 3'b010, K3 = 3'b100, NB = 3'b000;

  logic       clk = 1'b0;
  logic       rst;
  logic       BTN3, BTN2, BTN1;
  logic [3:0] SW;
  logic [7:0] LED;
  logic [6:0] digit4, digit3, digit2, digit1;

  always #5 clk = ~clk;

  atm_controller #(.LOCK_LONG_CYC(LONG), .LOCK_SHORT_CYC(SHORT)) dut (
    .clk(clk), .rst(rst), .BTN3(BTN3), .BTN2(BTN2), .BTN1(BTN1), .SW(SW),
    .LED(LED), .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1)
  );

  // op 0: press then check; op 1: press into a lock, time it, then check; op 2: press only
  typedef struct {
    int         op;
    logic [2:0] btn;
    logic [3:0] sw;
    int         lbit;
    int         len;
    logic [7:0] led;
    logic [6:0] d4, d3, d2, d1;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input int op, input logic [2:0] btn, input logic [3:0] sw, input int lbit,
                     input int len, input logic [7:0] led, input logic [6:0] d4, input logic [6:0] d3,
                     input logic [6:0] d2, input logic [6:0] d1);
    vec_t t;
    t.op = op; t.btn = btn; t.sw = sw; t.lbit = lbit; t.len = len;
    t.led = led; t.d4 = d4; t.d3 = d3; t.d2 = d2; t.d1 = d1;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] led, input logic [6:0] d4,
                       input logic [6:0] d3, input logic [6:0] d2, input logic [6:0] d1);
    checks++;
    if ({LED, digit4, digit3, digit2, digit1} !== {led, d4, d3, d2, d1}) begin
      failures++;
      $display("FAIL %s: got LED=%h digits=%h %h %h %h, want LED=%h digits=%h %h %h %h",
               name, LED, digit4, digit3, digit2, digit1, led, d4, d3, d2, d1);
    end
  endtask

  task automatic press(input logic [2:0] b, input logic [3:0] s);
    @(negedge clk);
    SW = s;
    {BTN3, BTN2, BTN1} = b;
    @(negedge clk);
    {BTN3, BTN2, BTN1} = NB;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_lock(input vec_t t, input string name);
    int n;
    int cnt;
    @(negedge clk);
    SW = t.sw;
    {BTN3, BTN2, BTN1} = t.btn;
    @(negedge clk);
    {BTN3, BTN2, BTN1} = NB;
    n = 0;
    while (!LED[t.lbit] && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!LED[t.lbit]) begin
      failures++;
      $display("FAIL %s lock_entry: LED=%h, want bit %0d set", name, LED, t.lbit);
    end else begin
      cnt = 0;
      while (LED[t.lbit] && cnt < 1000) begin
        cnt++;
        if (cnt == 10) BTN3 = 1'b1;   // must be ignored while locked
        if (cnt == 11) BTN3 = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (cnt != t.len) begin
        failures++;
        $display("FAIL %s lock_len: got %0d cycles, want %0d", name, cnt, t.len);
      end
    end
  endtask

  initial begin
    // scenario 1 / 2
    add(0, K3, 4'd0, 0, 0, 8'h02, S1, SB, SB, S3);
    add(0, K3, 4'd0, 0, 0, 8'h04, S2, S0, S0, S0);
    add(0, K3, 4'd0, 0, 0, 8'h08, S3, S0, S0, S0);
    add(0, K3, 4'd5, 0, 0, 8'h08, S3, S0, S0, S5);
    add(0, K1, 4'd5, 0, 0, 8'h04, S2, S0, S0, S5);
    add(0, K2, 4'd5, 0, 0, 8'h10, S4, SB, SB, S3);
    add(0, K3, 4'd0, 0, 0, 8'h20, S5, SB, SB, SB);
    add(0, K3, 4'd9, 0, 0, 8'h04, S2, S0, S0, S5);
    add(0, K1, 4'd9, 0, 0, 8'h01, S0, SB, SB, SB);
    // scenario 3: BTN2 is a no-op in PIN, then three wrong tries
    add(0, K3, 4'd9, 0, 0, 8'h02, S1, SB, SB, S3);
    add(0, K2, 4'd9, 0, 0, 8'h02, S1, SB, SB, S3);
    add(0, K3, 4'd0, 0, 0, 8'h02, S1, SB, SB, S2);
    add(0, K3, 4'd4, 0, 0, 8'h02, S1, SB, SB, S1);
    add(1, K3, 4'd2, 6, LONG, 8'h01, S0, SB, SB, SB);
    // scenario 4: withdraw, then insufficient funds
    add(0, K3, 4'd2, 0, 0, 8'h02, S1, SB, SB, S3);
    add(0, K3, 4'd9, 0, 0, 8'h04, S2, S0, S0, S5);
    add(0, K3, 4'd9, 0, 0, 8'h08, S3, S0, S0, S5);
    add(0, K2, 4'd4, 0, 0, 8'h08, S3, S0, S0, S1);
    add(1, K2, 4'd2, 7, SHORT, 8'h08, S3, S0, S0, S1);
    // scenario 5: wrong old PINs lock and log out; pin stays 9
    add(0, K1, 4'd2, 0, 0, 8'h04, S2, S0, S0, S1);
    add(0, K2, 4'd2, 0, 0, 8'h10, S4, SB, SB, S3);
    add(0, K3, 4'd4, 0, 0, 8'h10, S4, SB, SB, S2);
    add(0, K3, 4'd0, 0, 0, 8'h10, S4, SB, SB, S1);
    add(1, K3, 4'd14, 6, LONG, 8'h01, S0, SB, SB, SB);
    add(0, K3, 4'd14, 0, 0, 8'h02, S1, SB, SB, S3);
    add(0, K3, 4'd9, 0, 0, 8'h04, S2, S0, S0, S1);
    // coincident presses: BTN1 beats BTN3, BTN3 beats BTN2
    add(0, K3 | K1, 4'd9, 0, 0, 8'h01, S0, SB, SB, SB);
    add(0, K3, 4'd9, 0, 0, 8'h02, S1, SB, SB, S3);
    add(0, K3, 4'd9, 0, 0, 8'h04, S2, S0, S0, S1);
    add(0, K3 | K2, 4'd9, 0, 0, 8'h08, S3, S0, S0, S1);
    add(0, K2, 4'd1, 0, 0, 8'h08, S3, S0, S0, S0);
    add(0, K3 | K2, 4'd15, 0, 0, 8'h08, S3, S0, S1, S5);
    // scenario 6: build up to 240, then saturate at 255
    for (int i = 0; i < 15; i++) add(2, K3, 4'd15, 0, 0, 8'h00, SB, SB, SB, SB);
    add(0, K3, 4'd10, 0, 0, 8'h08, S3, S2, S5, S0);
    add(0, K3, 4'd15, 0, 0, 8'h08, S3, S2, S5, S5);
    add(0, K3, 4'd15, 0, 0, 8'h08, S3, S2, S5, S5);
    add(0, K2, 4'd15, 0, 0, 8'h08, S3, S2, S4, S0);
    add(0, K1, 4'd15, 0, 0, 8'h04, S2, S2, S4, S0);
    add(0, K1, 4'd15, 0, 0, 8'h01, S0, SB, SB, SB);
    add(0, K3, 4'd1, 0, 0, 8'h02, S1, SB, SB, S3);
    add(0, K3, 4'd1, 0, 0, 8'h02, S1, SB, SB, S2);
    add(0, K3, 4'd1, 0, 0, 8'h02, S1, SB, SB, S1);

    rst = 1'b1;
    {BTN3, BTN2, BTN1} = NB;
    SW = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_held", 8'h01, S0, SB, SB, SB);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_released", 8'h01, S0, SB, SB, SB);

    foreach (tbl[i]) begin
      case (tbl[i].op)
        0: begin
          press(tbl[i].btn, tbl[i].sw);
          check($sformatf("vec%0d", i), tbl[i].led, tbl[i].d4, tbl[i].d3, tbl[i].d2, tbl[i].d1);
        end
        1: begin
          run_lock(tbl[i], $sformatf("vec%0d", i));
          check($sformatf("vec%0d_after", i), tbl[i].led, tbl[i].d4, tbl[i].d3, tbl[i].d2, tbl[i].d1);
        end
        default: press(tbl[i].btn, tbl[i].sw);
      endcase
    end

    // third wrong try, then reset in the middle of the lock
    @(negedge clk);
    SW = 4'd1;
    BTN3 = 1'b1;
    @(negedge clk);
    BTN3 = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_lock", 8'h40, SL, SB, SB, SB);
    rst = 1'b1;
    #1;
    check("async_rst_in_lock", 8'h01, S0, SB, SB, SB);
    @(negedge clk);
    rst = 1'b0;
    press(K3, 4'd0);
    check("after_rst_pin", 8'h02, S1, SB, SB, S3);
    press(K3, 4'd0);
    check("after_rst_menu", 8'h04, S2, S0, S0, S0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
